// File: rtl/sound_pkg.sv
// Shared constants and types for the 68000 -> Z80 sound command path.
package sound_pkg;

  localparam logic [7:0] LATCH_EMPTY_DATA = 8'hff;
  localparam logic [7:0] STATUS_HI        = 8'hff;

  localparam int ST_PENDING  = 0;
  localparam int ST_OVERFLOW = 1;
  localparam int ST_FULL     = 2;

  // Queue operation for one clock, encoded as {push, pop}.
  typedef enum logic [1:0] {
    Q_IDLE = 2'b00,
    Q_POP  = 2'b01,
    Q_PUSH = 2'b10,
    Q_BOTH = 2'b11
  } q_op_e;

endpackage

// File: rtl/edge_rise.sv
// Registered CPU strobe with a one-clock rising-edge pulse. A strobe that is
// already high when reset releases must fall once before it can fire.
module edge_rise (
  input  logic clk,
  input  logic rst,
  input  logic strobe,
  output logic rise
);

  logic strobe_q;
  logic strobe_qq;
  logic armed;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its neighbours.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      strobe_q  <= 1'b0;
      strobe_qq <= 1'b0;
      armed     <= 1'b0;
    end else begin
      strobe_q  <= strobe;
      strobe_qq <= strobe_q;
      armed     <= armed | ~strobe;
    end
  end

  assign rise = strobe_q & ~strobe_qq & armed;

endmodule

// File: rtl/sound_latch.sv
// 68000 -> Z80 sound command queue: push on 68000 write edge, pop on Z80 ack
// edge, NMI to the Z80 while a command is waiting.
module sound_latch
  import sound_pkg::*;
#(
  parameter int DEPTH = 1,
  parameter int AW    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m68k_latch_cs,
  input  logic        m68k_sound_cs,
  input  logic        m68k_lds_n,
  input  logic [7:0]  m68k_din,
  output logic [15:0] m68k_dout,
  input  logic        z80_latch_cs,
  input  logic        z80_rd_n,
  input  logic        z80_wr_n,
  output logic [7:0]  z80_dout,
  output logic        z80_nmi_n,
  output logic        overflow
);

  localparam int            IW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] PTR_MASK = AW'(2 * DEPTH - 1);
  localparam logic [AW-1:0] FULL_CNT = AW'(DEPTH);

  // Reads are non-destructive and both outputs are gated upstream, so these
  // selects carry no state here.
  logic unused_sel;
  assign unused_sel = &{1'b0, m68k_sound_cs, z80_rd_n};

  logic          wr68, ack, push_ev, pop_ev;
  logic [AW-1:0] wp, rp, wp_nxt, rp_nxt, count;
  logic          empty, full, push_ok, pop_ok, nmi_nxt, ovf_set;
  logic [IW-1:0] widx, ridx;
  logic [7:0]    mem [DEPTH];
  logic [7:0]    status;
  q_op_e         op;

  assign wr68 = m68k_latch_cs & ~m68k_lds_n;
  assign ack  = z80_latch_cs & ~z80_wr_n;

  edge_rise u_wr_edge (
    .clk    (clk),
    .rst    (reset),
    .strobe (wr68),
    .rise   (push_ev)
  );

  edge_rise u_ack_edge (
    .clk    (clk),
    .rst    (reset),
    .strobe (ack),
    .rise   (pop_ev)
  );

  assign count = (wp - rp) & PTR_MASK;
  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);
  assign widx  = (DEPTH == 1) ? '0 : IW'(wp);
  assign ridx  = (DEPTH == 1) ? '0 : IW'(rp);

  // NOTE: every signal driven here gets a default first, so no path through
  // the block can leave one unassigned and infer a latch.
  always_comb begin
    pop_ok  = pop_ev & ~empty;
    push_ok = push_ev & (~full | pop_ok);
    ovf_set = push_ev & ~push_ok;
    op      = q_op_e'({push_ok, pop_ok});
    wp_nxt  = wp;
    rp_nxt  = rp;
    case (op)
      Q_PUSH:  wp_nxt = (wp + AW'(1)) & PTR_MASK;
      Q_POP:   rp_nxt = (rp + AW'(1)) & PTR_MASK;
      Q_BOTH: begin
        wp_nxt = (wp + AW'(1)) & PTR_MASK;
        rp_nxt = (rp + AW'(1)) & PTR_MASK;
      end
      default: ;
    endcase
    // An accepted pop always lifts NMI for one clock so a pending command
    // produces a fresh falling edge for the edge-triggered Z80 input.
    nmi_nxt = pop_ok | (empty & ~push_ok);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp        <= '0;
      rp        <= '0;
      z80_nmi_n <= 1'b1;
      overflow  <= 1'b0;
    end else begin
      wp        <= wp_nxt;
      rp        <= rp_nxt;
      z80_nmi_n <= nmi_nxt;
      overflow  <= overflow | ovf_set;
    end
  end

  // NOTE: the storage array has no reset; empty pointers mask its contents.
  always_ff @(posedge clk) begin
    if (push_ok) mem[widx] <= m68k_din;
  end

  always_comb begin
    status              = '0;
    status[ST_PENDING]  = ~empty;
    status[ST_OVERFLOW] = overflow;
    status[ST_FULL]     = full;
  end

  assign m68k_dout = {STATUS_HI, status};
  assign z80_dout  = empty ? LATCH_EMPTY_DATA : mem[ridx];

endmodule
